// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding, default timeout and lane width for the UART TX arbiter.
package uart_tx_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int LANE_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or above ptr, wrapping at NUM_REQ-1.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);
    int idx;
    always_comb begin
        winner = '0;
        any_req = 1'b0;
        idx = 0;
        // Scan from the farthest offset down so the closest request to ptr is assigned last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                winner = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX byte port among NUM_REQ requesters,
// with a per-grant stall timeout that revokes a hung grant.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [LANE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [LANE_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_pulse,
    output logic [ID_W-1:0]           timeout_id
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t state, state_n;
    logic [ID_W-1:0] ptr, winner, next_ptr;
    logic [CNT_W-1:0] cnt;
    logic any_req, can_load, accept, last_acc, expire;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(req_valid),
        .ptr(ptr),
        .winner(winner),
        .any_req(any_req)
    );

    assign busy = state == ST_GRANT;
    assign can_load = !tx_valid || tx_ready;
    assign req_ready = (busy && can_load) ? NUM_REQ'(1) << grant_id : '0;
    assign accept = |(req_ready & req_valid);
    assign last_acc = accept && req_last[grant_id];
    // An accept on the final stall cycle keeps the grant alive.
    assign expire = busy && !accept && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign next_ptr = grant_id == ID_W'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_n = state;
        state_n = (state == ST_IDLE) ? (any_req ? ST_GRANT : ST_IDLE)
                                     : ((last_acc || expire) ? ST_IDLE : ST_GRANT);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            ptr <= '0;
            cnt <= '0;
            grant_id <= '0;
            tx_valid <= 1'b0;
            tx_data <= '0;
            timeout_pulse <= 1'b0;
            timeout_id <= '0;
        end else begin
            state <= state_n;
            timeout_pulse <= expire;
            if (state == ST_IDLE && any_req) begin
                grant_id <= winner;
                cnt <= '0;
            end else if (accept) begin
                cnt <= '0;
            end else if (busy && !expire) begin
                cnt <= cnt + 1'b1;
            end
            if (last_acc || expire)
                ptr <= next_ptr;
            if (expire)
                timeout_id <= grant_id;
            // The held byte is delivered even after its grant is revoked.
            if (accept) begin
                tx_valid <= 1'b1;
                tx_data <= req_data[LANE_W*grant_id +: LANE_W];
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed stimulus with a handshake-fed scoreboard, packet-lock model
// and round-robin/timeout expectations derived from the arbitration rules.
module tb_uart_tx_arbiter;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_valid, tx_ready, busy, timeout_pulse;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id, timeout_id;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .grant_id(grant_id),
        .timeout_pulse(timeout_pulse), .timeout_id(timeout_id)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Pending bytes per requester ({last,data}) and expected TX stream entries ({src,last,data}).
    logic [8:0]  src_q[4][$];
    logic [10:0] exp_q[$];
    logic [10:0] tx_log[$];
    logic [3:0]  hs;
    int checks = 0, passed = 0, lock_viol = 0, owner = -1, mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    function automatic int pend();
        int s = exp_q.size() + int'(busy) + int'(tx_valid);
        for (int r = 0; r < 4; r++) s += src_q[r].size();
        return s;
    endfunction

    task automatic clear_q();
        for (int r = 0; r < 4; r++) src_q[r].delete();
        exp_q.delete();
        tx_log.delete();
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        clear_q();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        do begin
            @(negedge wb_clk_i);
            #3;
        end while (pend() > 0 && ++n < max);
        chk("drain", pend(), 0);
    endtask

    task automatic chk_log(input string nm, input int i, input logic [10:0] e);
        if (i < tx_log.size()) chk(nm, tx_log[i], e);
        else chk({nm, "_missing"}, tx_log.size(), i + 1);
    endtask

    // Requester driver: presents queue heads, records handshakes and tracks packet ownership.
    initial begin
        req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1; hs = '0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin hs = '0; owner = -1; end
            if (timeout_pulse) owner = -1;
            for (int r = 0; r < 4; r++)
                if (hs[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
            for (int r = 0; r < 4; r++) begin
                req_valid[r] = src_q[r].size() > 0;
                req_data[8*r +: 8] = src_q[r].size() > 0 ? src_q[r][0][7:0] : 8'h00;
                req_last[r] = src_q[r].size() > 0 ? src_q[r][0][8] : 1'b0;
            end
            tx_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : ($urandom_range(3) != 0);
            #1;
            hs = wb_rst_i ? 4'b0 : req_valid & req_ready;
            if ($countones(hs) > 1) lock_viol++;
            for (int r = 0; r < 4; r++)
                if (hs[r]) begin
                    if (owner >= 0 && owner != r) lock_viol++;
                    exp_q.push_back({2'(r), req_last[r], req_data[8*r +: 8]});
                    owner = req_last[r] ? -1 : r;
                end
        end
    end

    // Monitor: every TX transfer must match the oldest accepted byte.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge wb_clk_i);
            #2;
            if (!wb_rst_i && tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("tx_extra", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", tx_data, e[7:0]);
                    tx_log.push_back(e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, first, pulses, lv, tot;
        logic [7:0] d;
        wb_rst_i = 1'b1;
        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout_pulse", timeout_pulse, 0);
        chk("rst_timeout_id", timeout_id, 0);
        chk("rst_req_ready", req_ready, 0);
        do_reset();

        // Single packet from requester 2.
        @(posedge wb_clk_i); #1;
        push(2, 8'h55, 0); push(2, 8'hAA, 1);
        @(negedge wb_clk_i); #3;
        chk("t1_valid", req_valid[2], 1);
        chk("t1_arb_busy", busy, 0);
        @(negedge wb_clk_i); #3;
        chk("t1_grant", grant_id, 2);
        chk("t1_busy", busy, 1);
        chk("t1_ready", req_ready, 4'b0100);
        @(negedge wb_clk_i); #3;
        chk("t1_txv", tx_valid, 1);
        chk("t1_d0", tx_data, 8'h55);
        @(negedge wb_clk_i); #3;
        chk("t1_d1", tx_data, 8'hAA);
        chk("t1_busy_fall", busy, 0);
        wait_drain(50);

        // Round robin from pointer 0, twice.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            tx_log.delete();
            @(posedge wb_clk_i); #1;
            for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1);
            wait_drain(100);
            for (int i = 0; i < 4; i++) chk_log("rr_order", i, {2'(i), 1'b1, 8'h10 + 8'(i)});
        end

        // Packet lock: requester 1 waits for requester 0's whole packet.
        tx_log.delete();
        @(posedge wb_clk_i); #1;
        push(0, 8'hA0, 0); push(0, 8'hA1, 0); push(0, 8'hA2, 1); push(1, 8'hB0, 1);
        n = 0; lv = 0;
        do begin
            @(negedge wb_clk_i); #3;
            if (busy && grant_id == 0 && req_ready[1]) lv++;
        end while (pend() > 0 && ++n < 40);
        chk("lock_r1_ready", lv, 0);
        chk_log("lock_0", 0, {2'd0, 1'b0, 8'hA0});
        chk_log("lock_1", 1, {2'd0, 1'b0, 8'hA1});
        chk_log("lock_2", 2, {2'd0, 1'b1, 8'hA2});
        chk_log("lock_3", 3, {2'd1, 1'b1, 8'hB0});

        // Backpressure: tx_ready low for 5 cycles with 0x22 held.
        tx_log.delete();
        @(posedge wb_clk_i); #1;
        push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 0); push(2, 8'h24, 1);
        n = 0;
        do begin @(negedge wb_clk_i); #3; end while (!tx_valid && ++n < 20);
        chk("bp_first", tx_data, 8'h21);
        mode = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i); #3;
            chk("bp_hold_data", tx_data, 8'h22);
            chk("bp_hold_valid", tx_valid, 1);
            chk("bp_ready", req_ready, 0);
        end
        mode = 0;
        wait_drain(50);
        for (int i = 0; i < 4; i++) chk_log("bp_stream", i, {2'd2, i == 3, 8'h21 + 8'(i)});

        // Timeout: requester 3 hangs after one byte.
        tx_log.delete();
        @(posedge wb_clk_i); #1;
        push(3, 8'h3C, 0);
        n = 0;
        do begin @(negedge wb_clk_i); #3; end while (!hs[3] && ++n < 20);
        chk("to_accept", hs[3], 1);
        first = -1; pulses = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge wb_clk_i); #3;
            if (timeout_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        chk("to_delay", first - 1, 16);
        chk("to_pulses", pulses, 1);
        chk("to_id", timeout_id, 3);
        chk("to_busy", busy, 0);
        chk_log("to_byte", 0, {2'd3, 1'b0, 8'h3C});

        // Async reset with a byte held in the output register.
        tx_log.delete();
        mode = 1;
        @(posedge wb_clk_i); #1;
        push(0, 8'h31, 0); push(0, 8'h32, 0); push(0, 8'h33, 1);
        n = 0;
        do begin @(negedge wb_clk_i); #3; end while (!tx_valid && ++n < 20);
        chk("rs_held", tx_data, 8'h31);
        wb_rst_i = 1'b1;
        #1;
        chk("rs_txv", tx_valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ready", req_ready, 0);
        clear_q();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        mode = 0;
        @(posedge wb_clk_i); #1;
        push(0, 8'h7E, 1);
        wait_drain(50);
        chk_log("rs_after", 0, {2'd0, 1'b1, 8'h7E});
        chk("rs_grant", grant_id, 0);

        // Random packets with random backpressure.
        tx_log.delete();
        tot = 0;
        mode = 2;
        for (int c = 0; c < 400; c++) begin
            @(negedge wb_clk_i); #3;
            for (int r = 0; r < 4; r++)
                if (src_q[r].size() == 0 && $urandom_range(7) == 0) begin
                    n = $urandom_range(4, 1);
                    for (int b = 0; b < n; b++) begin
                        d = 8'($urandom);
                        push(r, d, b == n - 1);
                        tot++;
                    end
                end
        end
        mode = 0;
        wait_drain(600);
        chk("rand_total", tx_log.size(), tot);
        chk("lock_viol", lock_viol, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
